// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Outstanding long-latency writeback tracker for the vanilla core: per-entry age,
// one completion record per clear, per-class latency statistics and sticky protocol errors.
module vanilla_scoreboard_latency_tracker #(
    parameter int num_banks_p         = 2,
    parameter int reg_els_p           = 32,
    parameter int reg_addr_width_p    = 5,
    parameter int num_classes_p       = 8,
    parameter int class_width_p       = 3,
    parameter int counter_width_p     = 16,
    parameter int ignore_bank0_reg0_p = 1
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_i,
    input  logic [num_banks_p-1:0]                                set_v_i,
    input  logic [num_banks_p*reg_addr_width_p-1:0]               set_id_i,
    input  logic [num_banks_p*class_width_p-1:0]                  set_class_i,
    input  logic [num_banks_p-1:0]                                clear_v_i,
    input  logic [num_banks_p*reg_addr_width_p-1:0]               clear_id_i,
    input  logic                                                  stats_clear_i,
    output logic [num_banks_p*reg_els_p-1:0]                      pending_o,
    output logic [num_banks_p*reg_els_p*class_width_p-1:0]        class_o,
    output logic [num_banks_p*reg_els_p*counter_width_p-1:0]      age_o,
    output logic [num_banks_p-1:0]                                done_v_o,
    output logic [num_banks_p*reg_addr_width_p-1:0]               done_id_o,
    output logic [num_banks_p*class_width_p-1:0]                  done_class_o,
    output logic [num_banks_p*counter_width_p-1:0]                done_latency_o,
    output logic [num_classes_p*counter_width_p-1:0]              max_latency_o,
    output logic [num_classes_p*counter_width_p-1:0]              done_count_o,
    output logic [num_banks_p-1:0]                                double_set_o,
    output logic [num_banks_p-1:0]                                spurious_clear_o
);

    localparam int num_ent_lp = num_banks_p * reg_els_p;
    localparam int aw_lp      = reg_addr_width_p;
    localparam int cw_lp      = class_width_p;
    localparam int lw_lp      = counter_width_p;
    localparam logic [lw_lp-1:0] cnt_one_lp = {{(lw_lp-1){1'b0}}, 1'b1};

    logic [num_ent_lp-1:0]                 pending_q, pending_d;
    logic [num_ent_lp*cw_lp-1:0]           class_q, class_d;
    logic [num_ent_lp*lw_lp-1:0]           age_q, age_d;
    logic [num_banks_p-1:0]                done_v_q, done_v_d;
    logic [num_banks_p*aw_lp-1:0]          done_id_q, done_id_d;
    logic [num_banks_p*cw_lp-1:0]          done_class_q, done_class_d;
    logic [num_banks_p*lw_lp-1:0]          done_latency_q, done_latency_d;
    logic [num_classes_p*lw_lp-1:0]        max_latency_q, max_latency_d;
    logic [num_classes_p*lw_lp-1:0]        done_count_q, done_count_d;
    logic [num_banks_p-1:0]                double_set_q, double_set_d;
    logic [num_banks_p-1:0]                spurious_clear_q, spurious_clear_d;

    function automatic logic [lw_lp-1:0] sat_inc(input logic [lw_lp-1:0] v);
        return (&v) ? v : v + cnt_one_lp;
    endfunction

    always_comb begin
        pending_d        = pending_q;
        class_d          = class_q;
        age_d            = age_q;
        done_v_d         = '0;
        done_id_d        = done_id_q;
        done_class_d     = done_class_q;
        done_latency_d   = done_latency_q;
        max_latency_d    = stats_clear_i ? '0 : max_latency_q;
        done_count_d     = stats_clear_i ? '0 : done_count_q;
        double_set_d     = stats_clear_i ? '0 : double_set_q;
        spurious_clear_d = stats_clear_i ? '0 : spurious_clear_q;

        for (int e = 0; e < num_ent_lp; e++) begin
            if (pending_q[e]) age_d[e*lw_lp +: lw_lp] = sat_inc(age_q[e*lw_lp +: lw_lp]);
        end

        // Clear is applied before set so a same-id set/clear completes the old entry first.
        for (int b = 0; b < num_banks_p; b++) begin
            int   sid, cid, se, ce;
            logic sv, cv;
            sid = int'(set_id_i[b*aw_lp +: aw_lp]);
            cid = int'(clear_id_i[b*aw_lp +: aw_lp]);
            sv  = set_v_i[b] && (sid < reg_els_p) &&
                  !((ignore_bank0_reg0_p != 0) && (b == 0) && (sid == 0));
            cv  = clear_v_i[b] && (cid < reg_els_p) &&
                  !((ignore_bank0_reg0_p != 0) && (b == 0) && (cid == 0));
            se  = b * reg_els_p + sid;
            ce  = b * reg_els_p + cid;

            if (cv) begin
                if (pending_q[ce]) begin
                    done_v_d[b]                         = 1'b1;
                    done_id_d[b*aw_lp +: aw_lp]         = clear_id_i[b*aw_lp +: aw_lp];
                    done_class_d[b*cw_lp +: cw_lp]      = class_q[ce*cw_lp +: cw_lp];
                    done_latency_d[b*lw_lp +: lw_lp]    = sat_inc(age_q[ce*lw_lp +: lw_lp]);
                    pending_d[ce]                       = 1'b0;
                    age_d[ce*lw_lp +: lw_lp]            = '0;
                end else begin
                    spurious_clear_d[b] = 1'b1;
                end
            end

            if (sv) begin
                if (pending_q[se] && !(cv && (cid == sid))) double_set_d[b] = 1'b1;
                pending_d[se]              = 1'b1;
                class_d[se*cw_lp +: cw_lp] = set_class_i[b*cw_lp +: cw_lp];
                age_d[se*lw_lp +: lw_lp]   = '0;
            end
        end

        // Banks are folded in order so two same-class completions on one edge both count.
        for (int b = 0; b < num_banks_p; b++) begin
            int c;
            c = int'(done_class_d[b*cw_lp +: cw_lp]);
            if (done_v_d[b] && (c < num_classes_p)) begin
                done_count_d[c*lw_lp +: lw_lp] = sat_inc(done_count_d[c*lw_lp +: lw_lp]);
                if (done_latency_d[b*lw_lp +: lw_lp] > max_latency_d[c*lw_lp +: lw_lp])
                    max_latency_d[c*lw_lp +: lw_lp] = done_latency_d[b*lw_lp +: lw_lp];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q        <= '0;
            class_q          <= '0;
            age_q            <= '0;
            done_v_q         <= '0;
            done_id_q        <= '0;
            done_class_q     <= '0;
            done_latency_q   <= '0;
            max_latency_q    <= '0;
            done_count_q     <= '0;
            double_set_q     <= '0;
            spurious_clear_q <= '0;
        end else begin
            pending_q        <= pending_d;
            class_q          <= class_d;
            age_q            <= age_d;
            done_v_q         <= done_v_d;
            done_id_q        <= done_id_d;
            done_class_q     <= done_class_d;
            done_latency_q   <= done_latency_d;
            max_latency_q    <= max_latency_d;
            done_count_q     <= done_count_d;
            double_set_q     <= double_set_d;
            spurious_clear_q <= spurious_clear_d;
        end
    end

    assign pending_o        = pending_q;
    assign class_o          = class_q;
    assign age_o            = age_q;
    assign done_v_o         = done_v_q;
    assign done_id_o        = done_id_q;
    assign done_class_o     = done_class_q;
    assign done_latency_o   = done_latency_q;
    assign max_latency_o    = max_latency_q;
    assign done_count_o     = done_count_q;
    assign double_set_o     = double_set_q;
    assign spurious_clear_o = spurious_clear_q;

endmodule
